// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//
// Shares a single request/response bus between an instruction-fetch master
// (ibus) and a data-memory master (dbus). One master owns the bus per
// transaction. A transaction is one request, followed by either a read
// burst of RESP_BEATS beats or nothing for a write. Simultaneous requests
// alternate between the masters: the one that did not own the bus last wins.
//
// Ports
//   clk, reset                  sole clock; synchronous active-high reset
//   {i,d}bus_reqcyc/req/reqtag  master request, held until released
//   {i,d}bus_respack            master accepts the current response beat
//   {i,d}bus_respcyc            response beat valid, owner only
//   {i,d}bus_resp/resptag       bus response data and tag, always mirrored
//   bus_reqcyc/req/reqtag       request to the bus, valid only in REQ
//   bus_reqack                  bus took the request this cycle
//   bus_respcyc/resp/resptag    response beat from the bus
//   bus_respack                 response beat accepted by the owner
// ---------------------------------------------------------------------------
module bus_arbiter #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int RESP_BEATS     = 8
) (
  input  logic                      clk,
  input  logic                      reset,

  input  logic                      ibus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] ibus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  ibus_reqtag,
  input  logic                      ibus_respack,
  output logic                      ibus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] ibus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  ibus_resptag,

  input  logic                      dbus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] dbus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  dbus_reqtag,
  input  logic                      dbus_respack,
  output logic                      dbus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] dbus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  dbus_resptag,

  output logic                      bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      bus_respack
);

  // Wide enough to hold RESP_BEATS itself, so the counter never wraps.
  localparam int CNT_W = $clog2(RESP_BEATS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RESP_BEATS - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP, RELEASE} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  state_t           state, state_nxt;
  owner_t           owner, owner_nxt;
  owner_t           last_owner, last_owner_nxt;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;

  // Signals of whichever master currently holds the grant.
  logic                      own_reqcyc;
  logic [BUS_DATA_WIDTH-1:0] own_req;
  logic [BUS_TAG_WIDTH-1:0]  own_reqtag;
  logic                      own_respack;
  logic                      beat_fire;

  assign own_reqcyc  = (owner == OWN_D) ? dbus_reqcyc  : ibus_reqcyc;
  assign own_req     = (owner == OWN_D) ? dbus_req     : ibus_req;
  assign own_reqtag  = (owner == OWN_D) ? dbus_reqtag  : ibus_reqtag;
  assign own_respack = (owner == OWN_D) ? dbus_respack : ibus_respack;

  // A beat counts only when the bus offers it and the owner takes it.
  assign beat_fire = (state == RESP) && bus_respcyc && own_respack;

  // State register
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= OWN_I;
      last_owner <= OWN_I;
      beat_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      beat_cnt   <= beat_cnt_nxt;
    end
  end

  // Next-state logic
  // NOTE: every variable gets a hold-value default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    beat_cnt_nxt   = beat_cnt;
    case (state)
      IDLE: begin
        if (ibus_reqcyc || dbus_reqcyc) begin
          state_nxt = REQ;
          if (ibus_reqcyc && dbus_reqcyc) begin
            owner_nxt = (last_owner == OWN_I) ? OWN_D : OWN_I;
          end else begin
            owner_nxt = dbus_reqcyc ? OWN_D : OWN_I;
          end
        end
      end
      REQ: begin
        if (bus_reqack) begin
          if (own_reqtag[BUS_TAG_WIDTH-1]) begin
            state_nxt = RELEASE;  // write: no response burst follows
          end else begin
            state_nxt    = RESP;
            beat_cnt_nxt = '0;
          end
        end
      end
      RESP: begin
        if (beat_fire) begin
          beat_cnt_nxt = beat_cnt + 1'b1;
          if (beat_cnt == LAST_CNT) begin
            state_nxt = RELEASE;
          end
        end
      end
      RELEASE: begin
        // Owner keeps the grant until it drops its request.
        if (!own_reqcyc) begin
          state_nxt      = IDLE;
          last_owner_nxt = owner;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus_reqcyc   = (state == REQ);
    bus_req      = '0;
    bus_reqtag   = '0;
    bus_respack  = beat_fire;
    ibus_respcyc = 1'b0;
    dbus_respcyc = 1'b0;
    if (state == REQ) begin
      bus_req    = own_req;
      bus_reqtag = own_reqtag;
    end
    if (state == RESP) begin
      ibus_respcyc = bus_respcyc && (owner == OWN_I);
      dbus_respcyc = bus_respcyc && (owner == OWN_D);
    end
  end

  // Response data and tag go to both masters; only respcyc qualifies them.
  assign ibus_resp    = bus_resp;
  assign ibus_resptag = bus_resptag;
  assign dbus_resp    = bus_resp;
  assign dbus_resptag = bus_resptag;

endmodule

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
//
// Self-checking bench for bus_arbiter. A transaction-level reference model
// (pending request / beats remaining / releasing, plus owner history)
// predicts every output each cycle. Directed sequences cover the fetch read,
// alternating grants, the data write, stray beats and reset mid-burst; a
// long random phase follows.
// ---------------------------------------------------------------------------
module tb_bus_arbiter;

  localparam int DW    = 64;
  localparam int TW    = 13;
  localparam int BEATS = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cyc     [2];
  logic [DW-1:0] req     [2];
  logic [TW-1:0] rtag    [2];
  logic          respack [2];
  logic          bus_reqack, bus_respcyc;
  logic [DW-1:0] bus_resp;
  logic [TW-1:0] bus_resptag;

  logic          ibus_respcyc, dbus_respcyc;
  logic [DW-1:0] ibus_resp, dbus_resp;
  logic [TW-1:0] ibus_resptag, dbus_resptag;
  logic          bus_reqcyc;
  logic [DW-1:0] bus_req;
  logic [TW-1:0] bus_reqtag;
  logic          bus_respack;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: index 0 = ibus, 1 = dbus.
  bit m_pending;
  int m_beats_left;
  bit m_releasing;
  int m_owner;
  int m_last;

  // DUT outputs captured at the last checked negedge.
  logic          s_bus_reqcyc, s_bus_respack, s_irespcyc, s_drespcyc;
  logic [DW-1:0] s_bus_req, s_iresp;
  logic [TW-1:0] s_bus_reqtag;

  bus_arbiter #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .RESP_BEATS(BEATS)) dut (
    .clk          (clk),
    .reset        (reset),
    .ibus_reqcyc  (cyc[0]),
    .ibus_req     (req[0]),
    .ibus_reqtag  (rtag[0]),
    .ibus_respack (respack[0]),
    .ibus_respcyc (ibus_respcyc),
    .ibus_resp    (ibus_resp),
    .ibus_resptag (ibus_resptag),
    .dbus_reqcyc  (cyc[1]),
    .dbus_req     (req[1]),
    .dbus_reqtag  (rtag[1]),
    .dbus_respack (respack[1]),
    .dbus_respcyc (dbus_respcyc),
    .dbus_resp    (dbus_resp),
    .dbus_resptag (dbus_resptag),
    .bus_reqcyc   (bus_reqcyc),
    .bus_req      (bus_req),
    .bus_reqtag   (bus_reqtag),
    .bus_reqack   (bus_reqack),
    .bus_respcyc  (bus_respcyc),
    .bus_resp     (bus_resp),
    .bus_resptag  (bus_resptag),
    .bus_respack  (bus_respack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pending    = 1'b0;
    m_beats_left = 0;
    m_releasing  = 1'b0;
    m_owner      = 0;
    m_last       = 0;
  endtask

  task automatic quiet();
    reset       = 1'b0;
    bus_reqack  = 1'b0;
    bus_respcyc = 1'b0;
    bus_resp    = '0;
    bus_resptag = '0;
    for (int m = 0; m < 2; m++) begin
      cyc[m]     = 1'b0;
      req[m]     = '0;
      rtag[m]    = '0;
      respack[m] = 1'b0;
    end
  endtask

  // One clock cycle: inputs are already driven; compare at the negedge,
  // advance the model, then return just after the next rising edge.
  task automatic tick();
    logic in_resp, e_respack;
    @(negedge clk);
    s_bus_reqcyc  = bus_reqcyc;
    s_bus_req     = bus_req;
    s_bus_reqtag  = bus_reqtag;
    s_bus_respack = bus_respack;
    s_irespcyc    = ibus_respcyc;
    s_drespcyc    = dbus_respcyc;
    s_iresp       = ibus_resp;

    in_resp   = (m_beats_left > 0);
    e_respack = in_resp && bus_respcyc && respack[m_owner];
    check("bus_reqcyc",   DW'(bus_reqcyc),   DW'(m_pending));
    check("bus_req",      bus_req,           m_pending ? req[m_owner] : '0);
    check("bus_reqtag",   DW'(bus_reqtag),   m_pending ? DW'(rtag[m_owner]) : '0);
    check("bus_respack",  DW'(bus_respack),  DW'(e_respack));
    check("ibus_respcyc", DW'(ibus_respcyc), DW'(in_resp && bus_respcyc && m_owner == 0));
    check("dbus_respcyc", DW'(dbus_respcyc), DW'(in_resp && bus_respcyc && m_owner == 1));
    check("ibus_resp",    ibus_resp,         bus_resp);
    check("dbus_resptag", DW'(dbus_resptag), DW'(bus_resptag));

    if (reset) begin
      model_reset();
    end else if (m_pending) begin
      if (bus_reqack) begin
        m_pending = 1'b0;
        if (rtag[m_owner][TW-1]) m_releasing = 1'b1;
        else                     m_beats_left = BEATS;
      end
    end else if (m_beats_left > 0) begin
      if (e_respack) begin
        m_beats_left--;
        if (m_beats_left == 0) m_releasing = 1'b1;
      end
    end else if (m_releasing) begin
      if (!cyc[m_owner]) begin
        m_releasing = 1'b0;
        m_last      = m_owner;
      end
    end else if (cyc[0] || cyc[1]) begin
      m_owner   = (cyc[0] && cyc[1]) ? 1 - m_last : (cyc[1] ? 1 : 0);
      m_pending = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    quiet();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    reset = 1'b0;

    // Reset state: all outputs idle.
    tick();
    check("rst_bus_reqcyc", DW'(s_bus_reqcyc), '0);
    check("rst_bus_req", s_bus_req, '0);

    // Fetch read with ack in the third cycle and eight in-order beats.
    cyc[0] = 1'b1; req[0] = 64'h1000; rtag[0] = 13'h0001; respack[0] = 1'b1;
    tick();
    tick();
    check("rd_bus_req_wait", s_bus_req, 64'h1000);
    bus_reqack = 1'b1;
    tick();
    check("rd_bus_reqcyc", DW'(s_bus_reqcyc), 64'h1);
    bus_reqack = 1'b0;
    for (int k = 0; k < BEATS; k++) begin
      bus_respcyc = 1'b1; bus_resp = 64'hA0 + 64'(k); bus_resptag = 13'h0001;
      tick();
      check("rd_beat_valid", DW'(s_irespcyc), 64'h1);
      check("rd_beat_data", s_iresp, 64'hA0 + 64'(k));
    end
    bus_respcyc = 1'b0; cyc[0] = 1'b0;
    tick();
    tick();
    check("rd_idle_after", DW'(s_bus_reqcyc), '0);

    // Simultaneous writes after reset: D first, then I with no extra gap.
    reset_pulse();
    quiet();
    cyc[0] = 1'b1; req[0] = 64'h11; rtag[0] = 13'h1002;
    cyc[1] = 1'b1; req[1] = 64'h22; rtag[1] = 13'h1005;
    tick();
    bus_reqack = 1'b1;
    tick();
    check("arb_first_d", DW'(s_bus_reqtag), 64'h1005);
    bus_reqack = 1'b0; bus_respcyc = 1'b1;
    cyc[1] = 1'b0;
    tick();
    check("wr_no_respack", DW'(s_bus_respack), '0);
    tick();
    bus_reqack = 1'b1;
    tick();
    check("arb_then_i", DW'(s_bus_reqtag), 64'h1002);
    bus_reqack = 1'b0; cyc[0] = 1'b0;
    tick();
    tick();

    // Stray response beat while idle.
    quiet();
    bus_respcyc = 1'b1; bus_resp = 64'hDEAD;
    tick();
    check("stray_respack", DW'(s_bus_respack), '0);
    check("stray_irespcyc", DW'(s_irespcyc), '0);
    check("stray_drespcyc", DW'(s_drespcyc), '0);

    // Reset on the fourth beat of a read, then a fresh dbus request.
    quiet();
    cyc[0] = 1'b1; req[0] = 64'h2000; rtag[0] = 13'h0003; respack[0] = 1'b1;
    tick();
    bus_reqack = 1'b1;
    tick();
    bus_reqack = 1'b0; bus_respcyc = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; cyc[0] = 1'b0;
    cyc[1] = 1'b1; req[1] = 64'h3000; rtag[1] = 13'h0007; respack[1] = 1'b1;
    tick();
    check("rst_mid_respack", DW'(s_bus_respack), '0);
    check("rst_mid_irespcyc", DW'(s_irespcyc), '0);
    tick();
    check("rst_mid_regrant", s_bus_req, 64'h3000);

    // Random traffic; the model checks every cycle.
    for (int n = 0; n < 4000; n++) begin
      for (int m = 0; m < 2; m++) begin
        if (!cyc[m]) begin
          if ($urandom_range(3) == 0) begin
            cyc[m]      = 1'b1;
            req[m]      = {$urandom, $urandom};
            rtag[m]     = 13'($urandom);
            rtag[m][TW-1] = ($urandom_range(2) == 0);
          end
        end else if ($urandom_range(7) == 0) begin
          cyc[m] = 1'b0;
        end
        respack[m] = ($urandom_range(3) != 0);
      end
      bus_reqack  = ($urandom_range(1) == 1);
      bus_respcyc = ($urandom_range(3) != 0);
      bus_resp    = {$urandom, $urandom};
      bus_resptag = 13'($urandom);
      reset       = ($urandom_range(199) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
